// File: rtl/avl_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single Avalon memory controller.
// Read data is steered back to the issuing port through an in-order tag FIFO.
module avl_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 29,
  parameter int MAX_BURST  = 16,
  parameter int TAG_DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ram_rdy,

  input  logic                  a_wr_req,
  input  logic                  a_rd_req,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ready,
  output logic                  a_rdata_valid,

  input  logic                  b_wr_req,
  input  logic                  b_rd_req,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ready,
  output logic                  b_rdata_valid,

  output logic [DATA_WIDTH-1:0] rdata,

  input  logic                  avl_ready,
  output logic                  avl_write_req,
  output logic                  avl_read_req,
  output logic [ADDR_WIDTH-1:0] avl_addr,
  output logic [DATA_WIDTH-1:0] avl_wdata,
  input  logic [DATA_WIDTH-1:0] avl_rdata,
  input  logic                  avl_rdata_valid,

  output logic [1:0]            grant,
  output logic                  err_orphan
);

  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);
  localparam logic [PW:0]   TAG_FULL  = (PW+1)'(TAG_DEPTH);
  localparam logic [PW-1:0] PTR_LAST  = PW'(TAG_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

  state_t          state;
  logic            ptr_b;
  logic [BW-1:0]   burst_cnt;

  logic            tag_mem [TAG_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     tag_cnt;

  logic            req_a;
  logic            req_b;
  logic            granted;
  logic            sel_b;
  logic            sel_wr;
  logic            sel_rd;
  logic            sel_req;
  logic            other_req;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic            tag_full;
  logic            tag_empty;
  logic            issue_ok;
  logic            do_write;
  logic            do_read;
  logic            accept;
  logic            pop;
  logic            tag_out;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Command path: the owning port drives the Avalon side directly, gated so
  // nothing leaks out while idle or while reset is being applied.
  always_comb begin
    req_a     = a_wr_req | a_rd_req;
    req_b     = b_wr_req | b_rd_req;
    granted   = ((state == GRANT_A) || (state == GRANT_B)) && !reset;
    sel_b     = (state == GRANT_B);
    sel_wr    = sel_b ? b_wr_req : a_wr_req;
    sel_rd    = sel_b ? b_rd_req : a_rd_req;
    sel_addr  = sel_b ? b_addr   : a_addr;
    sel_wdata = sel_b ? b_wdata  : a_wdata;
    sel_req   = sel_wr | sel_rd;
    other_req = sel_b ? req_a : req_b;
    tag_full  = (tag_cnt == TAG_FULL);
    tag_empty = (tag_cnt == '0);

    issue_ok  = granted & avl_ready & ram_rdy;
    do_write  = issue_ok & sel_wr;
    do_read   = issue_ok & !sel_wr & sel_rd & !tag_full;
    accept    = do_write | do_read;

    a_ready       = accept & !sel_b;
    b_ready       = accept & sel_b;
    avl_write_req = do_write;
    avl_read_req  = do_read;
    avl_addr      = (granted & sel_req) ? sel_addr : '0;
    avl_wdata     = (granted & sel_wr) ? sel_wdata : '0;

    pop           = avl_rdata_valid & !tag_empty & !reset;
    tag_out       = tag_mem[rd_ptr];
    a_rdata_valid = pop & !tag_out;
    b_rdata_valid = pop & tag_out;
    rdata         = avl_rdata;
  end

  // Arbitration FSM; the whole thing freezes until the memory is calibrated.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= 2'b00;
      ptr_b     <= 1'b0;
      burst_cnt <= '0;
    end else if (ram_rdy) begin
      case (state)
        IDLE: begin
          if (req_a && (!req_b || !ptr_b)) begin
            state <= GRANT_A;
            grant <= 2'b01;
          end else if (req_b) begin
            state <= GRANT_B;
            grant <= 2'b10;
          end
        end
        GRANT_A, GRANT_B: begin
          if (!sel_req || (accept && burst_cnt == LAST_BEAT)) begin
            burst_cnt <= '0;
            ptr_b     <= !sel_b;
            if (other_req) begin
              state <= sel_b ? GRANT_A : GRANT_B;
              grant <= sel_b ? 2'b01 : 2'b10;
            end else begin
              state <= IDLE;
              grant <= 2'b00;
            end
          end else if (accept) begin
            burst_cnt <= burst_cnt + BW'(1);
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_read) tag_mem[wr_ptr] <= sel_b;
  end

  // Tag bookkeeping; data arriving with nothing outstanding is latched as an error.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      tag_cnt    <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (do_read) wr_ptr <= next_ptr(wr_ptr);
      if (pop)     rd_ptr <= next_ptr(rd_ptr);
      case ({do_read, pop})
        2'b10:   tag_cnt <= tag_cnt + (PW+1)'(1);
        2'b01:   tag_cnt <= tag_cnt - (PW+1)'(1);
        default: tag_cnt <= tag_cnt;
      endcase
      if (avl_rdata_valid && tag_empty) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_avl_mem_arbiter.sv
// Directed bench for avl_mem_arbiter: burst limits, round-robin, read routing,
// tag FIFO full/free, stall, orphan data and reset with reads outstanding.
module tb_avl_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 29;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ram_rdy = 1'b1;
  logic          a_wr_req = 1'b0, a_rd_req = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          a_ready, a_rdata_valid;
  logic          b_wr_req = 1'b0, b_rd_req = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          b_ready, b_rdata_valid;
  logic [DW-1:0] rdata;
  logic          avl_ready = 1'b1;
  logic          avl_write_req, avl_read_req;
  logic [AW-1:0] avl_addr;
  logic [DW-1:0] avl_wdata;
  logic [DW-1:0] avl_rdata = '0;
  logic          avl_rdata_valid = 1'b0;
  logic [1:0]    grant;
  logic          err_orphan;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  avl_mem_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(16), .TAG_DEPTH(8)
  ) dut (
    .clk(clk), .reset(reset), .ram_rdy(ram_rdy),
    .a_wr_req(a_wr_req), .a_rd_req(a_rd_req), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_rdata_valid(a_rdata_valid),
    .b_wr_req(b_wr_req), .b_rd_req(b_rd_req), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ready(b_ready), .b_rdata_valid(b_rdata_valid),
    .rdata(rdata),
    .avl_ready(avl_ready), .avl_write_req(avl_write_req), .avl_read_req(avl_read_req),
    .avl_addr(avl_addr), .avl_wdata(avl_wdata), .avl_rdata(avl_rdata),
    .avl_rdata_valid(avl_rdata_valid),
    .grant(grant), .err_orphan(err_orphan)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic aw, input logic ar, input logic [AW-1:0] aa,
                               input logic bw, input logic br, input logic [AW-1:0] ba);
    a_wr_req = aw;
    a_rd_req = ar;
    a_addr   = aa;
    a_wdata  = 32'hA000_0000 | DW'(aa);
    b_wr_req = bw;
    b_rd_req = br;
    b_addr   = ba;
    b_wdata  = 32'hB000_0000 | DW'(ba);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(0, 0, '0, 0, 0, '0);
    avl_rdata_valid = 1'b0;
    avl_rdata       = '0;
    avl_ready       = 1'b1;
    reset           = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [DW-1:0] rd_vals [5];
  logic          exp_acc;
  logic          exp_a;
  int            k;

  initial begin
    rd_vals = '{32'hA0, 32'hA1, 32'hA2, 32'hB0, 32'hB1};

    // Reset state and single-port 20-word write with burst split 16 + 4
    doReset();
    #1;
    checkOutput("rst grant", grant, 2'b00);
    checkOutput("rst a_ready", a_ready, 0);
    checkOutput("rst b_ready", b_ready, 0);
    checkOutput("rst avl_write_req", avl_write_req, 0);
    checkOutput("rst avl_read_req", avl_read_req, 0);
    checkOutput("rst avl_addr", avl_addr, 0);
    checkOutput("rst avl_wdata", avl_wdata, 0);
    checkOutput("rst err_orphan", err_orphan, 0);
    checkOutput("rst a_rdata_valid", a_rdata_valid, 0);
    applyStimulus(1, 0, AW'(2), 0, 0, '0);
    #1;
    checkOutput("t1 idle grant", grant, 2'b00);
    checkOutput("t1 idle a_ready", a_ready, 0);
    k = 0;
    for (int n = 1; n <= 21; n++) begin
      tick();
      applyStimulus(1, 0, AW'(2 + k), 0, 0, '0);
      #1;
      exp_acc = (n <= 16) || (n >= 18);
      checkOutput($sformatf("t1 grant n=%0d", n), grant, exp_acc ? 2'b01 : 2'b00);
      checkOutput($sformatf("t1 a_ready n=%0d", n), a_ready, exp_acc);
      checkOutput($sformatf("t1 avl_write_req n=%0d", n), avl_write_req, exp_acc);
      if (exp_acc) begin
        checkOutput($sformatf("t1 avl_addr n=%0d", n), avl_addr, 2 + k);
        k++;
      end
    end
    tick();
    applyStimulus(0, 0, '0, 0, 0, '0);
    #1;
    checkOutput("t1 drop grant", grant, 2'b01);
    checkOutput("t1 drop a_ready", a_ready, 0);
    tick();
    checkOutput("t1 end grant", grant, 2'b00);

    // Both ports writing continuously: A16, B16, A16 back to back
    doReset();
    applyStimulus(1, 0, AW'('h100), 1, 0, AW'('h200));
    #1;
    checkOutput("t2 idle grant", grant, 2'b00);
    for (int n = 1; n <= 48; n++) begin
      tick();
      exp_a = (n <= 16) || (n >= 33);
      checkOutput($sformatf("t2 grant n=%0d", n), grant, exp_a ? 2'b01 : 2'b10);
      checkOutput($sformatf("t2 a_ready n=%0d", n), a_ready, exp_a);
      checkOutput($sformatf("t2 b_ready n=%0d", n), b_ready, !exp_a);
      checkOutput($sformatf("t2 avl_addr n=%0d", n), avl_addr, exp_a ? 'h100 : 'h200);
      checkOutput($sformatf("t2 avl_write_req n=%0d", n), avl_write_req, 1);
    end

    // A reads 3, B reads 2, data returned in order and routed by tag
    doReset();
    for (int n = 0; n <= 11; n++) begin
      if (n > 0) tick();
      applyStimulus(0, n <= 3, AW'('h10 + n), 0, (n >= 4) && (n <= 6), AW'('h20 + n));
      avl_rdata_valid = (n >= 6) && (n <= 10);
      avl_rdata       = avl_rdata_valid ? rd_vals[n-6] : '0;
      #1;
      checkOutput($sformatf("t3 a_ready n=%0d", n), a_ready, (n >= 1) && (n <= 3));
      checkOutput($sformatf("t3 b_ready n=%0d", n), b_ready, (n >= 5) && (n <= 6));
      checkOutput($sformatf("t3 avl_read_req n=%0d", n), avl_read_req,
                  ((n >= 1) && (n <= 3)) || ((n >= 5) && (n <= 6)));
      checkOutput($sformatf("t3 a_rdata_valid n=%0d", n), a_rdata_valid, (n >= 6) && (n <= 8));
      checkOutput($sformatf("t3 b_rdata_valid n=%0d", n), b_rdata_valid, (n >= 9) && (n <= 10));
      if ((n >= 6) && (n <= 10))
        checkOutput($sformatf("t3 rdata n=%0d", n), rdata, rd_vals[n-6]);
    end
    checkOutput("t3 err_orphan", err_orphan, 0);

    // Tag FIFO fills at 8 reads; writes still pass; one return frees one slot
    doReset();
    applyStimulus(0, 1, AW'('h40), 0, 0, '0);
    for (int n = 1; n <= 10; n++) begin
      tick();
      checkOutput($sformatf("t4 a_ready n=%0d", n), a_ready, n <= 8);
      checkOutput($sformatf("t4 avl_read_req n=%0d", n), avl_read_req, n <= 8);
    end
    tick();
    applyStimulus(0, 0, AW'('h40), 1, 0, AW'('h80));
    #1;
    checkOutput("t4 handover b_ready", b_ready, 0);
    tick();
    checkOutput("t4 b grant", grant, 2'b10);
    checkOutput("t4 b_ready full", b_ready, 1);
    checkOutput("t4 avl_write_req", avl_write_req, 1);
    tick();
    applyStimulus(0, 0, '0, 0, 0, '0);
    avl_rdata_valid = 1'b1;
    avl_rdata       = 32'h55;
    #1;
    checkOutput("t4 a_rdata_valid", a_rdata_valid, 1);
    checkOutput("t4 b_rdata_valid", b_rdata_valid, 0);
    checkOutput("t4 rdata", rdata, 32'h55);
    tick();
    avl_rdata_valid = 1'b0;
    applyStimulus(0, 1, AW'('h48), 0, 0, '0);
    #1;
    checkOutput("t4 idle grant", grant, 2'b00);
    tick();
    checkOutput("t4 freed a_ready", a_ready, 1);
    tick();
    checkOutput("t4 refull a_ready", a_ready, 0);

    // avl_ready stall freezes the burst; orphan data sets the sticky flag
    doReset();
    applyStimulus(1, 0, AW'('h300), 0, 0, '0);
    for (int n = 1; n <= 21; n++) begin
      tick();
      avl_ready = !((n >= 6) && (n <= 9));
      if (n == 21) begin
        applyStimulus(0, 0, '0, 0, 0, '0);
        avl_rdata_valid = 1'b1;
        avl_rdata       = 32'h77;
      end
      #1;
      exp_acc = (n <= 5) || ((n >= 10) && (n <= 20));
      checkOutput($sformatf("t5 grant n=%0d", n), grant, (n <= 20) ? 2'b01 : 2'b00);
      checkOutput($sformatf("t5 a_ready n=%0d", n), a_ready, exp_acc);
      checkOutput($sformatf("t5 avl_write_req n=%0d", n), avl_write_req, exp_acc);
      checkOutput($sformatf("t5 avl_read_req n=%0d", n), avl_read_req, 0);
      if (n == 20) checkOutput("t5 err_orphan before", err_orphan, 0);
      if (n == 21) begin
        checkOutput("t5 orphan a_rdata_valid", a_rdata_valid, 0);
        checkOutput("t5 orphan b_rdata_valid", b_rdata_valid, 0);
      end
    end
    for (int n = 22; n <= 24; n++) begin
      tick();
      avl_rdata_valid = 1'b0;
      #1;
      checkOutput($sformatf("t5 err_orphan n=%0d", n), err_orphan, 1);
    end

    // Reset with three reads outstanding; the stale return is an orphan
    doReset();
    #1;
    checkOutput("t6 err_orphan cleared", err_orphan, 0);
    applyStimulus(0, 1, AW'('h500), 0, 0, '0);
    for (int n = 1; n <= 3; n++) begin
      tick();
      checkOutput($sformatf("t6 a_ready n=%0d", n), a_ready, 1);
    end
    tick();
    reset = 1'b1;
    applyStimulus(0, 1, AW'('h500), 1, 0, AW'('h600));
    tick();
    reset           = 1'b0;
    avl_rdata_valid = 1'b1;
    avl_rdata       = 32'hDEAD;
    #1;
    checkOutput("t6 grant", grant, 2'b00);
    checkOutput("t6 a_ready", a_ready, 0);
    checkOutput("t6 b_ready", b_ready, 0);
    checkOutput("t6 avl_write_req", avl_write_req, 0);
    checkOutput("t6 avl_read_req", avl_read_req, 0);
    checkOutput("t6 avl_addr", avl_addr, 0);
    checkOutput("t6 avl_wdata", avl_wdata, 0);
    checkOutput("t6 stale a_rdata_valid", a_rdata_valid, 0);
    checkOutput("t6 stale b_rdata_valid", b_rdata_valid, 0);
    checkOutput("t6 err_orphan pre", err_orphan, 0);
    tick();
    avl_rdata_valid = 1'b0;
    applyStimulus(0, 0, '0, 0, 0, '0);
    #1;
    checkOutput("t6 err_orphan set", err_orphan, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
